apb_multi_slave_mem: RTL and testbench

Parametrised APB4 completer model serving NUM_SLAVES independent word memories, one per Pselx line. It extends the fixed 4-select, 32-bit APB signal set with configurable widths, per-transfer wait states (Pready), byte strobes, error response (Pslverr) and a sticky protocol-violation flag. It sits on the APB side of the AHB-to-APB bridge as the responding peripheral for bridge verification and system simulation.

---
 rtl/apb_multi_slave_mem_if.sv | 41 ++++
 rtl/apb_multi_slave_mem.sv | 159 +++++++++++++++
 tb/tb_apb_multi_slave_mem.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_multi_slave_mem_if.sv
// APB4 bus bundle between a requester (master) and apb_multi_slave_mem (slave).
// Signals:
//   Pselx     - one-hot bank select, NUM_SLAVES wide
//   Penable   - access-phase indicator
//   Pwrite    - 1 = write, 0 = read
//   Paddr     - byte address
//   Pwdata    - write data
//   Pstrb     - write byte enables
//   Pwait_cfg - wait states for this transfer, sampled in setup
//   Prdata    - read data
//   Pready    - transfer-complete strobe
//   Pslverr   - error response, valid only with Pready
interface apb_multi_slave_mem_if #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WAIT_W     = 4
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [NUM_SLAVES-1:0] Pselx;
  logic                  Penable;
  logic                  Pwrite;
  logic [ADDR_WIDTH-1:0] Paddr;
  logic [DATA_WIDTH-1:0] Pwdata;
  logic [STRB_W-1:0]     Pstrb;
  logic [WAIT_W-1:0]     Pwait_cfg;
  logic [DATA_WIDTH-1:0] Prdata;
  logic                  Pready;
  logic                  Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb, Pwait_cfg,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata, Pstrb, Pwait_cfg,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_multi_slave_mem.sv
// APB4 completer serving NUM_SLAVES independent word memories, one per Pselx
// line, with programmable wait states, byte strobes, error response and a
// sticky protocol-violation flag.
// Ports:
//   Pclk      - clock, rising edge
//   Preset    - synchronous active-high reset
//   bus       - APB slave modport (Pselx/Penable/Pwrite/Paddr/Pwdata/Pstrb/
//               Pwait_cfg in; Prdata/Pready/Pslverr out, combinational)
//   proto_err - sticky protocol-violation flag, cleared only by Preset
module apb_multi_slave_mem #(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic                 Pclk,
  input  logic                 Preset,
  apb_multi_slave_mem_if.slave bus,
  output logic                 proto_err
);
  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned BYTE_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SEL_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic [NUM_SLAVES-1:0] sel;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } req_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              proto_err_d;

  logic                  pready, pslverr, commit;
  logic [DATA_WIDTH-1:0] prdata;

  // Storage; valid bits give every word a reset value of zero without
  // having to clear the whole array.
  logic [DATA_WIDTH-1:0]            mem [NUM_SLAVES][DEPTH];
  logic [NUM_SLAVES-1:0][DEPTH-1:0] valid;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      widx;
  logic [SEL_W-1:0]      bank;
  logic                  misaligned, out_of_range, err;
  logic [DATA_WIDTH-1:0] cur_word, merged;

  // Decode of the captured request: bank, word, error and strobe merge.
  always_comb begin
    word_idx = req_q.addr >> BYTE_LSB;
    widx     = word_idx[IDX_W-1:0];
    bank     = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (req_q.sel[i]) bank = SEL_W'(i);
    end
    misaligned   = (req_q.addr & ADDR_WIDTH'(STRB_W - 1)) != '0;
    out_of_range = word_idx >= ADDR_WIDTH'(DEPTH);
    err          = !$onehot(req_q.sel) || misaligned || out_of_range;
    cur_word     = valid[bank][widx] ? mem[bank][widx] : '0;
    merged       = cur_word;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (req_q.strb[b]) merged[8*b +: 8] = req_q.wdata[8*b +: 8];
    end
  end

  // Next-state and bus responses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    proto_err_d = proto_err;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Pselx != '0) begin
          if (!bus.Penable) begin
            req_d   = '{sel: bus.Pselx, addr: bus.Paddr, write: bus.Pwrite,
                        wdata: bus.Pwdata, strb: bus.Pstrb};
            cnt_d   = bus.Pwait_cfg;
            state_d = ACCESS;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus.Penable && (bus.Pselx == req_q.sel)) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
          end else begin
            pready  = 1'b1;
            pslverr = err;
            state_d = IDLE;
            if (!err) begin
              if (req_q.write) commit = 1'b1;
              else             prdata = cur_word;
            end
          end
        end else begin
          // Penable dropped or select changed mid-transfer: abandon it.
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset aborts whatever is in flight and silences the bus.
    if (Preset) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = '0;
      commit  = 1'b0;
    end
  end

  // FSM and captured-request registers.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      proto_err <= proto_err_d;
    end
  end

  // Word validity.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      valid <= '0;
    end else if (commit) begin
      valid[bank][widx] <= 1'b1;
    end
  end

  // Word storage, whole-word write of the strobe-merged value.
  always_ff @(posedge Pclk) begin
    if (commit) mem[bank][widx] <= merged;
  end

  assign bus.Pready  = pready;
  assign bus.Pslverr = pslverr;
  assign bus.Prdata  = prdata;
endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// Directed bench for apb_multi_slave_mem: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_apb_multi_slave_mem;
  localparam int unsigned NUM_SLAVES = 4;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DEPTH      = 256;
  localparam int unsigned WAIT_W     = 4;
  localparam int          MAX_LAT    = 40;

  logic clk;
  logic rst;
  logic proto_err;

  int n_checks = 0;
  int n_pass   = 0;

  apb_multi_slave_mem_if #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .WAIT_W(WAIT_W)
  ) bus ();

  apb_multi_slave_mem #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH), .WAIT_W(WAIT_W)
  ) dut (
    .Pclk(clk),
    .Preset(rst),
    .bus(bus.slave),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.Pselx   = '0;
    bus.Penable = 1'b0;
  endtask

  // One full transfer; returns latency in access cycles (0 = never ready).
  // Paddr/Pwdata/Pwrite are scrambled during access and must be ignored.
  task automatic xfer(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [3:0] waits, output logic [31:0] rdata,
                      output logic err, output int lat);
    tick();
    bus.Pselx     = sel;
    bus.Penable   = 1'b0;
    bus.Pwrite    = wr;
    bus.Paddr     = addr;
    bus.Pwdata    = wdata;
    bus.Pstrb     = strb;
    bus.Pwait_cfg = waits;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    tick();
    bus.Penable = 1'b1;
    bus.Paddr   = addr ^ 32'h4;
    bus.Pwdata  = ~wdata;
    bus.Pwrite  = ~wr;
    for (int k = 1; k <= MAX_LAT; k++) begin
      @(negedge clk);
      if (bus.Pready) begin
        lat   = k;
        rdata = bus.Prdata;
        err   = bus.Pslverr;
        break;
      end
      tick();
    end
  endtask

  task automatic do_wr(input string tag, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [3:0] waits, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    xfer(sel, addr, 1'b1, data, strb, waits, rd, e, lat);
    check({tag, "_lat"}, 64'(lat), 64'(int'(waits) + 1));
    check({tag, "_err"}, 64'(e), 64'(exp_err));
  endtask

  task automatic do_rd(input string tag, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [3:0] waits, input logic [31:0] exp_data,
                       input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    xfer(sel, addr, 1'b0, 32'h0, 4'hF, waits, rd, e, lat);
    check({tag, "_lat"}, 64'(lat), 64'(int'(waits) + 1));
    check({tag, "_err"}, 64'(e), 64'(exp_err));
    check({tag, "_data"}, 64'(rd), 64'(exp_data));
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    bus.Pwrite    = 1'b0;
    bus.Paddr     = '0;
    bus.Pwdata    = '0;
    bus.Pstrb     = '0;
    bus.Pwait_cfg = '0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_pready", 64'(bus.Pready), 64'h0);
    check("rst_pslverr", 64'(bus.Pslverr), 64'h0);
    check("rst_prdata", 64'(bus.Prdata), 64'h0);
    check("rst_proto_err", 64'(proto_err), 64'h0);
    tick();
    rst = 1'b0;

    // Write then back-to-back read, zero waits
    do_wr("wr10", 4'b0001, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, 1'b0);
    do_rd("rd10", 4'b0001, 32'h10, 4'd0, 32'hDEADBEEF, 1'b0);

    // Three wait states on an untouched bank
    do_rd("wait3", 4'b0100, 32'h0, 4'd3, 32'h0, 1'b0);

    // Byte strobes: bytes 0 and 2 replaced
    do_wr("strb_full", 4'b0010, 32'h8, 32'h11223344, 4'hF, 4'd1, 1'b0);
    do_wr("strb_part", 4'b0010, 32'h8, 32'hAABBCCDD, 4'b0101, 4'd0, 1'b0);
    do_rd("strb_rd", 4'b0010, 32'h8, 4'd2, 32'h11BB33DD, 1'b0);
    do_wr("strb_none", 4'b0010, 32'h8, 32'hFFFFFFFF, 4'b0000, 4'd0, 1'b0);
    do_rd("strb_none_rd", 4'b0010, 32'h8, 4'd0, 32'h11BB33DD, 1'b0);

    // Banks are independent
    do_rd("bank3_10", 4'b1000, 32'h10, 4'd0, 32'h0, 1'b0);

    // Out of range: index 0x100 must not alias onto word 0
    do_wr("oor_wr", 4'b0001, 32'h400, 32'hCAFEF00D, 4'hF, 4'd0, 1'b1);
    do_rd("oor_word0", 4'b0001, 32'h0, 4'd0, 32'h0, 1'b0);
    do_rd("oor_rd", 4'b0001, 32'h400, 4'd1, 32'h0, 1'b1);

    // Misaligned
    do_rd("mis_rd", 4'b0001, 32'h2, 4'd0, 32'h0, 1'b1);
    do_wr("mis_wr", 4'b0001, 32'h12, 32'h0, 4'hF, 4'd0, 1'b1);
    do_rd("mis_keep", 4'b0001, 32'h10, 4'd0, 32'hDEADBEEF, 1'b0);

    // Select not one-hot
    do_rd("sel_multi", 4'b0011, 32'h10, 4'd0, 32'h0, 1'b1);

    tick();
    bus_idle();
    @(negedge clk);
    check("proto_clean", 64'(proto_err), 64'h0);

    // Penable dropped mid-wait
    tick();
    bus.Pselx = 4'b0001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h30; bus.Pwdata = 32'h12345678; bus.Pstrb = 4'hF;
    bus.Pwait_cfg = 4'd5;
    tick();
    bus.Penable = 1'b1;
    tick();
    tick();
    bus.Penable = 1'b0;
    @(negedge clk);
    check("abort_pready", 64'(bus.Pready), 64'h0);
    tick();
    bus_idle();
    @(negedge clk);
    check("abort_proto", 64'(proto_err), 64'h1);
    do_rd("abort_nocommit", 4'b0001, 32'h30, 4'd0, 32'h0, 1'b0);
    tick();
    bus_idle();
    repeat (3) tick();
    @(negedge clk);
    check("proto_sticky", 64'(proto_err), 64'h1);

    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("proto_cleared", 64'(proto_err), 64'h0);

    // Penable high with no setup
    tick();
    bus.Pselx = 4'b0100; bus.Penable = 1'b1; bus.Pwrite = 1'b0;
    @(negedge clk);
    check("noset_pready", 64'(bus.Pready), 64'h0);
    tick();
    bus_idle();
    @(negedge clk);
    check("noset_proto", 64'(proto_err), 64'h1);

    // Reset hits the cycle that would otherwise complete a one-wait write
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.Pselx = 4'b0001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h20; bus.Pwdata = 32'h55AA55AA; bus.Pstrb = 4'hF;
    bus.Pwait_cfg = 4'd1;
    tick();
    bus.Penable = 1'b1;
    @(negedge clk);
    check("rmid_wait1", 64'(bus.Pready), 64'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rmid_pready", 64'(bus.Pready), 64'h0);
    tick();
    bus_idle();
    tick();
    rst = 1'b0;
    do_rd("rmid_rd20", 4'b0001, 32'h20, 4'd0, 32'h0, 1'b0);
    do_rd("rmid_rd10", 4'b0001, 32'h10, 4'd0, 32'h0, 1'b0);
    tick();
    bus_idle();
    @(negedge clk);
    check("rmid_proto", 64'(proto_err), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
